// File: rtl/code_fetch_server.sv
// ============================================================================
// Module      : code_fetch_server
// Description : CPU code-fetch responder. Serves 16-bit words from a byte-wide
//               memory bus and keeps a one-word sequential prefetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module code_fetch_server #(
   parameter int IPR_WIDTH = 16,
   parameter int MEM_AW    = 17,
   parameter int CNT_W     = 16
) (
   input  logic                 sysclk,
   input  logic                 sysreset_n,
   input  logic [IPR_WIDTH-1:0] code_addr,
   output logic [15:0]          code_in,
   output logic                 code_ready,
   output logic [MEM_AW-1:0]    mem_addr,
   output logic                 mem_rd,
   input  logic                 mem_ack,
   input  logic [7:0]           mem_rdata,
   output logic [CNT_W-1:0]     miss_count
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FETCH_LO = 2'd1,
      ST_FETCH_HI = 2'd2
   } state_t;

   state_t                 r_state,      w_state_nxt;
   logic                   r_code_ready, w_code_ready_nxt;
   logic [15:0]            r_code_in,    w_code_in_nxt;
   logic [MEM_AW-1:0]      r_mem_addr,   w_mem_addr_nxt;
   logic                   r_mem_rd,     w_mem_rd_nxt;
   logic [CNT_W-1:0]       r_miss_count, w_miss_count_nxt;
   logic                   r_pf_valid,   w_pf_valid_nxt;
   logic [IPR_WIDTH-1:0]   r_pf_addr,    w_pf_addr_nxt;
   logic [15:0]            r_pf_data,    w_pf_data_nxt;
   logic [IPR_WIDTH-1:0]   r_fetch_addr, w_fetch_addr_nxt;
   logic [7:0]             r_lo_byte,    w_lo_byte_nxt;

   logic                   w_hit;
   logic                   w_byte_done;
   logic [IPR_WIDTH-1:0]   w_addr_inc;
   logic [CNT_W-1:0]       w_cnt_inc;

   assign w_hit       = r_pf_valid && (code_addr == r_pf_addr);
   assign w_byte_done = r_mem_rd && mem_ack;
   assign w_addr_inc  = code_addr + {{(IPR_WIDTH-1){1'b0}}, 1'b1};
   assign w_cnt_inc   = r_miss_count + {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge sysclk or negedge sysreset_n) begin
      if (!sysreset_n) begin
         r_state      <= ST_IDLE;
         r_code_ready <= 1'b0;
         r_code_in    <= '0;
         r_mem_addr   <= '0;
         r_mem_rd     <= 1'b0;
         r_miss_count <= '0;
         r_pf_valid   <= 1'b0;
         r_pf_addr    <= '0;
         r_pf_data    <= '0;
         r_fetch_addr <= '0;
         r_lo_byte    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_code_ready <= w_code_ready_nxt;
         r_code_in    <= w_code_in_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_rd     <= w_mem_rd_nxt;
         r_miss_count <= w_miss_count_nxt;
         r_pf_valid   <= w_pf_valid_nxt;
         r_pf_addr    <= w_pf_addr_nxt;
         r_pf_data    <= w_pf_data_nxt;
         r_fetch_addr <= w_fetch_addr_nxt;
         r_lo_byte    <= w_lo_byte_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_code_ready_nxt = 1'b0;
      w_code_in_nxt    = r_code_in;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_rd_nxt     = r_mem_rd;
      w_miss_count_nxt = r_miss_count;
      w_pf_valid_nxt   = r_pf_valid;
      w_pf_addr_nxt    = r_pf_addr;
      w_pf_data_nxt    = r_pf_data;
      w_fetch_addr_nxt = r_fetch_addr;
      w_lo_byte_nxt    = r_lo_byte;

      case (r_state)
         ST_IDLE: begin
            w_mem_rd_nxt = 1'b0;
            if (w_hit) begin
               // Deliver buffered word and immediately prefetch the next one
               w_code_ready_nxt = 1'b1;
               w_code_in_nxt    = r_pf_data;
               w_pf_valid_nxt   = 1'b0;
               w_fetch_addr_nxt = w_addr_inc;
               w_mem_addr_nxt   = {w_addr_inc, 1'b0};
            end else begin
               if (!(&r_miss_count)) begin
                  w_miss_count_nxt = w_cnt_inc;
               end
               w_fetch_addr_nxt = code_addr;
               w_mem_addr_nxt   = {code_addr, 1'b0};
            end
            w_state_nxt = ST_FETCH_LO;
         end

         ST_FETCH_LO: begin
            // Request rises one cycle after entry so mem_rd always has a gap between bytes
            if (!r_mem_rd) begin
               w_mem_rd_nxt = 1'b1;
            end else if (w_byte_done) begin
               w_lo_byte_nxt  = mem_rdata;
               w_mem_rd_nxt   = 1'b0;
               w_mem_addr_nxt = {r_fetch_addr, 1'b1};
               w_state_nxt    = ST_FETCH_HI;
            end
         end

         ST_FETCH_HI: begin
            if (!r_mem_rd) begin
               w_mem_rd_nxt = 1'b1;
            end else if (w_byte_done) begin
               w_pf_data_nxt  = {mem_rdata, r_lo_byte};
               w_pf_addr_nxt  = r_fetch_addr;
               w_pf_valid_nxt = 1'b1;
               w_mem_rd_nxt   = 1'b0;
               w_state_nxt    = ST_IDLE;
            end
         end

         default: begin
            w_mem_rd_nxt = 1'b0;
            w_state_nxt  = ST_IDLE;
         end
      endcase
   end

   assign code_ready = r_code_ready;
   assign code_in    = r_code_in;
   assign mem_addr   = r_mem_addr;
   assign mem_rd     = r_mem_rd;
   assign miss_count = r_miss_count;

endmodule

`default_nettype wire

// File: tb/tb_code_fetch_server.sv
// ============================================================================
// Module      : tb_code_fetch_server
// Description : Directed self-checking bench for code_fetch_server.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_code_fetch_server;

   localparam int IPR_WIDTH = 16;
   localparam int MEM_AW    = 17;
   localparam int CNT_W     = 4;

   logic                 sysclk     = 1'b0;
   logic                 sysreset_n = 1'b0;
   logic [IPR_WIDTH-1:0] code_addr  = '0;
   logic [15:0]          code_in;
   logic                 code_ready;
   logic [MEM_AW-1:0]    mem_addr;
   logic                 mem_rd;
   logic                 mem_ack    = 1'b0;
   logic [7:0]           mem_rdata  = 8'h00;
   logic [CNT_W-1:0]     miss_count;

   int checks = 0;
   int errors = 0;
   int wait_states = 0;
   int ack_mode = 0;       // 0 normal responder, 1 toggle ack, 2 one stray ack pulse
   int wcnt = 0;
   int rd_in_reset = 0;
   logic [MEM_AW-1:0] ack_log[$];

   code_fetch_server #(
      .IPR_WIDTH (IPR_WIDTH),
      .MEM_AW    (MEM_AW),
      .CNT_W     (CNT_W)
   ) dut (
      .sysclk     (sysclk),
      .sysreset_n (sysreset_n),
      .code_addr  (code_addr),
      .code_in    (code_in),
      .code_ready (code_ready),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .miss_count (miss_count)
   );

   always #5 sysclk = ~sysclk;

   function automatic logic [15:0] word_val(input logic [15:0] w);
      if (w == 16'h0000) return 16'h1234;
      return {~w[7:0], w[7:0] ^ w[15:8]};
   endfunction

   function automatic logic [7:0] byte_val(input logic [16:0] b);
      logic [15:0] wv;
      wv = word_val(b[16:1]);
      return b[0] ? wv[15:8] : wv[7:0];
   endfunction

   // Byte-wide memory model with programmable wait states
   always @(posedge sysclk) begin
      #1;
      if (ack_mode == 1) begin
         mem_ack   = ~mem_ack;
         mem_rdata = 8'hEE;
      end else if (ack_mode == 2) begin
         mem_ack   = 1'b1;
         mem_rdata = 8'hEE;
         ack_mode  = 0;
      end else if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_rd) begin
         if (wcnt >= wait_states) begin
            mem_ack   = 1'b1;
            mem_rdata = byte_val(mem_addr);
            ack_log.push_back(mem_addr);
            wcnt      = 0;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   always @(negedge sysclk) begin
      if (!sysreset_n && mem_rd) rd_in_reset++;
   end

   task automatic fetch(input logic [15:0] a, output logic [15:0] d);
      bit ok;
      ok = 1'b0;
      d = '0;
      code_addr = a;
      for (int n = 0; n < 300; n++) begin
         @(negedge sysclk);
         if (code_ready) begin
            ok = 1'b1;
            d  = code_in;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL fetch_timeout addr=%h: code_ready=0 after 300 cycles, required 1", a);
      end
   endtask

   task automatic test_reset();
      sysreset_n = 1'b0;
      ack_mode = 1;
      code_addr = 16'h0000;
      repeat (6) @(negedge sysclk);
      checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL reset_code_ready got=%b exp=0", code_ready); end
      checks++; if (code_in !== 16'h0000) begin errors++; $display("FAIL reset_code_in got=%h exp=0000", code_in); end
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
      checks++; if (mem_addr !== 17'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (miss_count !== 4'h0) begin errors++; $display("FAIL reset_miss_count got=%h exp=0", miss_count); end
      checks++; if (rd_in_reset !== 0) begin errors++; $display("FAIL reset_rd_seen got=%0d exp=0", rd_in_reset); end
      ack_mode = 0;
      @(negedge sysclk);
      ack_log.delete();
      sysreset_n = 1'b1;
   endtask

   task automatic test_cold_miss();
      logic [15:0] d;
      bit seen;
      fetch(16'h0000, d);
      checks++; if (d !== 16'h1234) begin errors++; $display("FAIL cold_data got=%h exp=1234", d); end
      checks++; if (miss_count !== 4'd1) begin errors++; $display("FAIL cold_miss_count got=%0d exp=1", miss_count); end
      checks++;
      if (ack_log.size() < 2 || ack_log[0] !== 17'h0 || ack_log[1] !== 17'h1) begin
         errors++; $display("FAIL cold_addr_seq size=%0d exp bytes 00000,00001", ack_log.size());
      end
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge sysclk);
         if (mem_rd) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen || mem_addr !== 17'h2) begin
         errors++; $display("FAIL cold_prefetch rd=%b addr=%h exp rd=1 addr=00002", seen, mem_addr);
      end
   endtask

   task automatic test_sequential();
      logic [15:0] d;
      int bad;
      for (int w = 1; w < 8; w++) begin
         fetch(16'(w), d);
         checks++;
         if (d !== word_val(16'(w))) begin
            errors++; $display("FAIL seq_data word=%0d got=%h exp=%h", w, d, word_val(16'(w)));
         end
      end
      @(negedge sysclk);
      checks++;
      if (code_ready !== 1'b0 || code_in !== word_val(16'd7)) begin
         errors++; $display("FAIL seq_hold ready=%b code_in=%h exp ready=0 code_in=%h", code_ready, code_in, word_val(16'd7));
      end
      checks++; if (miss_count !== 4'd1) begin errors++; $display("FAIL seq_miss_count got=%0d exp=1", miss_count); end
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (i >= ack_log.size() || ack_log[i] !== 17'(i)) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL seq_addr_order bad_entries=%0d exp=0", bad); end
   endtask

   task automatic test_branch_mid_prefetch();
      logic [15:0] d;
      int k;
      fetch(16'h0100, d);
      checks++; if (d !== word_val(16'h0100)) begin errors++; $display("FAIL branch_data got=%h exp=%h", d, word_val(16'h0100)); end
      checks++; if (miss_count !== 4'd2) begin errors++; $display("FAIL branch_miss_count got=%0d exp=2", miss_count); end
      k = -1;
      foreach (ack_log[i]) if (ack_log[i] === 17'h200) k = i;
      checks++;
      if (k < 2 || k + 1 >= ack_log.size() || ack_log[k-2] !== 17'h10 || ack_log[k-1] !== 17'h11 || ack_log[k+1] !== 17'h201) begin
         errors++; $display("FAIL branch_addr_seq idx=%0d exp 00010,00011,00200,00201", k);
      end
   endtask

   task automatic test_wait_wrap();
      logic [15:0] d;
      int k;
      wait_states = 3;
      fetch(16'hFFFF, d);
      checks++; if (d !== word_val(16'hFFFF)) begin errors++; $display("FAIL wrap_data got=%h exp=%h", d, word_val(16'hFFFF)); end
      checks++; if (miss_count !== 4'd3) begin errors++; $display("FAIL wrap_miss_count got=%0d exp=3", miss_count); end
      fetch(16'h0000, d);
      checks++; if (d !== 16'h1234) begin errors++; $display("FAIL wrap_word0 got=%h exp=1234", d); end
      checks++; if (miss_count !== 4'd3) begin errors++; $display("FAIL wrap_hit_count got=%0d exp=3", miss_count); end
      k = -1;
      foreach (ack_log[i]) if (ack_log[i] === 17'h1FFFE) k = i;
      checks++;
      if (k < 0 || k + 3 >= ack_log.size() || ack_log[k+1] !== 17'h1FFFF || ack_log[k+2] !== 17'h0 || ack_log[k+3] !== 17'h1) begin
         errors++; $display("FAIL wrap_addr_seq idx=%0d exp 1FFFE,1FFFF,00000,00001", k);
      end
      wait_states = 0;
   endtask

   task automatic test_reset_mid_fetch_and_saturate();
      logic [15:0] d;
      bit seen;
      int exp;
      code_addr = 16'h0040;
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge sysclk);
         if (mem_rd && mem_addr === 17'h81) begin seen = 1'b1; break; end
      end
      checks++; if (!seen) begin errors++; $display("FAIL midhi_reach got=0 exp=1"); end
      sysreset_n = 1'b0;
      #1;
      checks++;
      if (code_ready !== 1'b0 || code_in !== 16'h0 || mem_rd !== 1'b0 || mem_addr !== 17'h0 || miss_count !== 4'h0) begin
         errors++; $display("FAIL midhi_async_reset ready=%b in=%h rd=%b addr=%h cnt=%h exp all 0",
                            code_ready, code_in, mem_rd, mem_addr, miss_count);
      end
      repeat (2) @(negedge sysclk);
      ack_mode = 2;
      sysreset_n = 1'b1;
      fetch(16'h0040, d);
      checks++; if (d !== word_val(16'h0040)) begin errors++; $display("FAIL restart_data got=%h exp=%h", d, word_val(16'h0040)); end
      checks++; if (miss_count !== 4'd1) begin errors++; $display("FAIL restart_miss_count got=%0d exp=1", miss_count); end
      for (int i = 0; i < 20; i++) begin
         fetch(16'h0300 + 16'(2 * i), d);
         exp = (i + 2 > 15) ? 15 : i + 2;
         checks++;
         if (d !== word_val(16'h0300 + 16'(2 * i))) begin
            errors++; $display("FAIL sat_data iter=%0d got=%h exp=%h", i, d, word_val(16'h0300 + 16'(2 * i)));
         end
         checks++;
         if (miss_count !== 4'(exp)) begin
            errors++; $display("FAIL sat_miss_count iter=%0d got=%0d exp=%0d", i, miss_count, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_sequential();
      test_branch_mid_prefetch();
      test_wait_wrap();
      test_reset_mid_fetch_and_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
